// File: rtl/rnd_stream_m.sv
// XNOR-feedback LFSR word generator with a valid/ready output stream and seedable state.
// Optional lock-up seed substitution is enabled by defining RNDGEN_LOCKUP_DET_EN.
module rnd_stream_m #(
    parameter int              LEN   = 31,
    parameter logic [LEN-1:0]  TAPS  = 31'h4800_0000,
    parameter int              OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    input  logic [LEN-1:0]   seed,
    output logic             seed_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [31:0]      word_cnt,
    output logic             lock_err
);

    // Handshakes: a seed is taken when seed_valid && seed_ready, a word moves when
    // out_valid && out_ready; both are sampled on the rising edge of clk.
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t             state_q, state_d;
    logic [LEN-1:0]     lfsr_q, lfsr_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [31:0]        word_cnt_q, word_cnt_d;

    logic [LEN-1:0]     gen_s;
    logic [OUT_W-1:0]   gen_word;
    logic               fb;
    logic [LEN-1:0]     seed_eff;
    logic               seed_acc;
    logic               xfer;

    // lfsr_q bit i-1 holds s[i]; the output bit is s[LEN] taken before each step.
    always_comb begin
        gen_s    = lfsr_q;
        gen_word = '0;
        fb       = 1'b1;
        for (int k = 0; k < OUT_W; k++) begin
            gen_word[k] = gen_s[LEN-1];
            fb = 1'b1;
            for (int t = 0; t < LEN; t++) begin
                if (TAPS[t]) fb = fb ~^ gen_s[t];
            end
            gen_s = {gen_s[LEN-2:0], fb};
        end
    end

`ifdef RNDGEN_LOCKUP_DET_EN
    logic lock_err_q;
    // All ones is the XNOR fixed point; it is swapped for the all-zero state.
    assign seed_eff = (&seed) ? '0 : seed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock_err_q <= 1'b0;
        else if (seed_acc && (&seed)) lock_err_q <= 1'b1;
    end
    assign lock_err = lock_err_q;
`else
    assign seed_eff = seed;
    assign lock_err = 1'b0;
`endif

    assign seed_ready = (state_q != LOAD);
    assign seed_acc   = seed_valid && seed_ready;
    assign xfer       = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        word_cnt_d  = word_cnt_q;
        case (state_q)
            IDLE: begin
                state_d     = RUN;
                out_data_d  = gen_word;
                lfsr_d      = gen_s;
                out_valid_d = 1'b1;
            end
            LOAD: begin
                state_d     = RUN;
                out_data_d  = gen_word;
                lfsr_d      = gen_s;
                out_valid_d = 1'b1;
            end
            RUN: begin
                if (xfer) begin
                    out_data_d = gen_word;
                    lfsr_d     = gen_s;
                    word_cnt_d = word_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A seed overrides whatever the stream would have done on this edge.
        if (seed_acc) begin
            lfsr_d      = seed_eff;
            out_valid_d = 1'b0;
            word_cnt_d  = '0;
            state_d     = LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: doc/rnd_stream_m.md
RND_STREAM_M -- requirements
Module: rnd_stream_m

Interface
REQ-001 SHALL have parameter LEN, default 31: LFSR length in bits, legal range 3..64.
REQ-002 SHALL have parameter TAPS, default 31'h4800_0000 (taps 31, 28): LEN-bit feedback mask; bit i-1 set selects tap i.
REQ-003 SHALL have parameter OUT_W, default 8: bits produced per output word, legal range 1..LEN.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port seed_valid, input, 1 bit: seed offered.
REQ-007 SHALL have port seed, input, LEN bits: seed value.
REQ-008 SHALL have port seed_ready, output, 1 bit: seed accepted when seed_valid && seed_ready.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-010 SHALL have port out_ready, input, 1 bit: sink accepts the word; transfer = out_valid && out_ready.
REQ-011 SHALL have port out_data, output, OUT_W bits: random word.
REQ-012 SHALL have port word_cnt, output, 32 bits: count of transfers since the last reset or seed load.
REQ-013 SHALL have port lock_err, output, 1 bit: sticky lock-up flag (see Configuration).

Function
REQ-014 SHALL implement the LFSR step on state s[1:LEN]: r = 1, then r = r XNOR s[t] for every tap t; next state = {r, s[1:LEN-1]}.
REQ-015 SHALL produce each word over OUT_W unrolled steps in one cycle: bit k (LSB = k 0) = s[LEN] before step k.
REQ-016 SHALL implement states IDLE, LOAD and RUN; reset enters IDLE.
REQ-017 SHALL move from IDLE to RUN one cycle after reset release, loading the first word from state 0 and setting out_valid = 1, unless a seed is accepted in that cycle.
REQ-018 SHALL, in RUN, on a transfer, load the next word and advance the LFSR by OUT_W steps on the same edge, keeping out_valid = 1 for full throughput.
REQ-019 SHALL, while out_valid = 1 and out_ready = 0, hold out_data, the LFSR state and word_cnt stable.
REQ-020 SHALL drive seed_ready = 1 in IDLE and RUN, and 0 in LOAD.
REQ-021 SHALL, on seed acceptance in IDLE or RUN, load the LFSR with seed, clear out_valid, clear word_cnt and enter LOAD; the current word is discarded.
REQ-022 SHALL, on simultaneous transfer and seed acceptance, count the transfer as completed, then apply REQ-021; word_cnt = 0 afterwards.
REQ-023 SHALL, in LOAD, compute the first word from the seeded state, set out_valid = 1 and enter RUN after exactly one cycle.
REQ-024 SHALL increment word_cnt by 1 per transfer and wrap from 0xFFFF_FFFF to 0.

Reset
REQ-025 SHALL apply the following while rst = 1, independent of clk: state = IDLE, LFSR = all zeros, out_valid = 0, out_data = 0, word_cnt = 0, lock_err = 0, seed_ready = 1.
REQ-026 SHALL, on reset mid-stream or mid-LOAD, abandon any pending word or seed without a partial transfer.

Configuration
REQ-027 SHALL, when RNDGEN_LOCKUP_DET_EN is defined, replace an accepted all-ones seed (the XNOR lock-up state) with all zeros and set lock_err = 1 until reset.
REQ-028 SHALL, when RNDGEN_LOCKUP_DET_EN is not defined, load the seed unchanged and tie lock_err to 0; an all-ones seed yields all-ones words forever.

Verification
REQ-029 SHALL cover: defaults, reset release, out_ready = 1 -> out_valid rises one cycle later; words 0..2 = 0x00; the stream matches a bit-serial model; word_cnt increments every cycle.
REQ-030 SHALL cover: out_ready = 0 for 10 cycles mid-stream -> out_data and word_cnt unchanged; the stream resumes with no lost or repeated word.
REQ-031 SHALL cover: seed 0x1234_5678 accepted in the same cycle as a transfer -> word_cnt = 0, out_valid low one cycle, next word = model output from seed.
REQ-032 SHALL cover: LEN = 4, TAPS = 4'b1100, OUT_W = 1 -> the output sequence repeats with period 15 and the LFSR never reaches 4'b1111.
REQ-033 SHALL cover: all-ones seed -> with the macro, lock_err = 1 and the stream equals the zero-seed stream; without it, out_data = all ones permanently.
REQ-034 SHALL cover: rst pulsed asynchronously between edges during LOAD -> out_valid = 0 immediately, IDLE, and the REQ-029 sequence restarts.
